// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Sequences loads and stores between the CPU memory stage and a word-organised
//   data RAM. Each accepted request gets one RAM cycle (or none for a bad access)
//   followed by one response.
//
//   Loads always read the full word; byte/half lane selection and sign/zero
//   extension happen here. Stores pass size straight to the RAM write mode.
//
// Ports
//   clk, clr                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                 request fields, latched on acceptance
//   resp_valid/resp_ready     response handshake
//   resp_rdata, resp_err      extended load data, error flag
//   ram_addr, ram_din,
//   ram_mode, ram_str,
//   ram_sel                   RAM control, active for one cycle in ACCESS
//   ram_dout                  RAM read data (combinational)
//
// State table
//   state    | meaning
//   S_IDLE   | ready for a request; checks alignment on acceptance
//   S_ACCESS | single RAM cycle; store writes, load data captured
//   S_RESP   | response held until resp_ready
module mem_access_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic [1:0]            ram_mode,
  output logic                  ram_str,
  output logic                  ram_sel,
  input  logic [31:0]           ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    req_bad;
  logic [7:0]              byte_lane;
  logic [15:0]             half_lane;
  logic [31:0]             load_ext;

  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = (req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // Lane extraction works on the full word read; the RAM's own narrow read
  // muxing is deliberately bypassed.
  always_comb begin
    byte_lane = ram_dout[7:0];
    case (addr_q[1:0])
      2'b00:   byte_lane = ram_dout[7:0];
      2'b01:   byte_lane = ram_dout[15:8];
      2'b10:   byte_lane = ram_dout[23:16];
      default: byte_lane = ram_dout[31:24];
    endcase
    half_lane = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = uns_q ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_ext = ram_dout;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'd0;
          err_d   = req_bad;
          state_d = req_bad ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        rdata_d = we_q ? 32'd0 : load_ext;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // The RAM writes on the edge that leaves ACCESS; a clr on that same edge
  // must suppress the write, so the strobe is gated by clr directly.
  assign ram_sel  = (state_q == S_ACCESS) && !clr;
  assign ram_str  = (state_q == S_ACCESS) && we_q && !clr;
  assign ram_addr = addr_q;
  assign ram_din  = wdata_q;
  assign ram_mode = ((state_q == S_ACCESS) && we_q) ? size_q : 2'b10;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [11:0] ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic [1:0]  ram_mode;
  logic        ram_str, ram_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_mode(ram_mode),
    .ram_str(ram_str), .ram_sel(ram_sel), .ram_dout(ram_dout)
  );

  // Word RAM with byte/half/word write modes and combinational read.
  logic [31:0] ram_mem [0:1023];
  logic        ram_wipe;
  assign ram_dout = ram_mem[ram_addr[11:2]];

  always @(posedge clk) begin
    if (ram_wipe) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= 32'd0;
    end else if (ram_sel && ram_str) begin
      case (ram_mode)
        2'b00: ram_mem[ram_addr[11:2]][8*ram_addr[1:0] +: 8] <= ram_din[7:0];
        2'b01: ram_mem[ram_addr[11:2]][16*ram_addr[1] +: 16] <= ram_din[15:0];
        default: ram_mem[ram_addr[11:2]] <= ram_din;
      endcase
    end
  end

  // Reference memory: plain byte array, little-endian.
  logic [7:0] ref_mem [0:4095];

  logic        exp_active = 1'b0;
  logic        exp_err, exp_we;
  logic [1:0]  exp_size;
  logic [11:0] exp_addr;
  logic [31:0] exp_rdata, exp_wdata;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic model_bad(input logic [1:0] size, input logic [11:0] addr);
    if (size == 2'b11) return 1'b1;
    if (size == 2'b01 && (addr % 2) != 0) return 1'b1;
    if (size == 2'b10 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [11:0] addr);
    logic [31:0] v;
    int nbytes;
    nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    v = 32'd0;
    for (int k = nbytes - 1; k >= 0; k--) v = (v << 8) | 32'(ref_mem[addr + 12'(k)]);
    if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | ~((32'd1 << (8*nbytes)) - 32'd1);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [11:0] addr);
    logic [11:0] b;
    b = {addr[11:2], 2'b00};
    return {ref_mem[b + 12'd3], ref_mem[b + 12'd2], ref_mem[b + 12'd1], ref_mem[b]};
  endfunction

  // Cycle-by-cycle compare against the expectation of the transaction in flight.
  logic prev_str = 1'b0;
  always @(negedge clk) begin
    if (ram_str) chk("str_twice", 32'(prev_str), 32'd0);
    prev_str = ram_str;
    if (exp_active && !clr) begin
      if (resp_valid) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
      end
      if (ram_sel) begin
        chk("sel_legal", 32'(exp_err), 32'd0);
        chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
        chk("ram_str", 32'(ram_str), 32'(exp_we));
        if (exp_we) begin
          chk("ram_mode_st", 32'(ram_mode), 32'(exp_size));
          chk("ram_din", ram_din, exp_wdata);
        end else begin
          chk("ram_mode_ld", 32'(ram_mode), 32'd2);
        end
      end else begin
        chk("str_no_sel", 32'(ram_str), 32'd0);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wdata,
                       input int hold, output logic [31:0] got, output logic got_err);
    int lat;
    int exp_lat;
    logic [31:0] held;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    exp_err   = model_bad(size, addr);
    exp_we    = we;
    exp_size  = size;
    exp_addr  = addr;
    exp_wdata = wdata;
    exp_rdata = (exp_err || we) ? 32'd0 : model_load(size, uns, addr);
    exp_lat   = exp_err ? 1 : 2;
    exp_active = 1'b1;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    chk("resp_latency", 32'(lat), 32'(exp_lat));
    held = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_stable", resp_rdata, held);
      chk("bp_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    got = resp_rdata;
    got_err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    exp_active = 1'b0;
    @(negedge clk);
    chk("resp_taken", 32'(resp_valid), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
    if (we && !exp_err) begin
      case (size)
        2'b00: ref_mem[addr] = wdata[7:0];
        2'b01: begin
          ref_mem[addr] = wdata[7:0];
          ref_mem[addr + 12'd1] = wdata[15:8];
        end
        default: for (int k = 0; k < 4; k++) ref_mem[addr + 12'(k)] = wdata[8*k +: 8];
      endcase
    end
    chk("ram_word", ram_mem[addr[11:2]], ref_word(addr));
  endtask

  logic [31:0] r;
  logic        e;

  initial begin
    clr = 1'b1; ram_wipe = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 12'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_str", 32'(ram_str), 32'd0);
    chk("rst_sel", 32'(ram_sel), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_din", ram_din, 32'd0);
    chk("rst_mode", 32'(ram_mode), 32'd2);
    clr = 1'b0; ram_wipe = 1'b0;

    // clr over a store sitting in ACCESS
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 12'h020;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_pending_sel", 32'(ram_sel), 32'd1);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_str", 32'(ram_str), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_ram", ram_mem[12'h020 >> 2], 32'd0);
    clr = 1'b0;

    issue(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 0, r, e);
    chk("sw_rdata", r, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'd0, 0, r, e);
    chk("lw_lit", r, 32'hDEADBEEF);
    chk("lw_err", 32'(e), 32'd0);
    issue(1'b0, 2'b00, 1'b0, 12'h013, 32'd0, 0, r, e);
    chk("lb_lit", r, 32'hFFFFFFDE);
    issue(1'b0, 2'b00, 1'b1, 12'h013, 32'd0, 0, r, e);
    chk("lbu_lit", r, 32'h000000DE);
    issue(1'b0, 2'b01, 1'b0, 12'h012, 32'd0, 0, r, e);
    chk("lh_lit", r, 32'hFFFFDEAD);
    issue(1'b0, 2'b01, 1'b1, 12'h010, 32'd0, 0, r, e);
    chk("lhu_lit", r, 32'h0000BEEF);
    issue(1'b0, 2'b00, 1'b0, 12'h010, 32'd0, 1, r, e);
    chk("lb_pos_lit", r, 32'hFFFFFFEF);
    issue(1'b1, 2'b00, 1'b0, 12'h011, 32'h00000012, 0, r, e);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'd0, 0, r, e);
    chk("sb_lw_lit", r, 32'hDEAD12EF);
    issue(1'b0, 2'b00, 1'b0, 12'h011, 32'd0, 0, r, e);
    chk("lb_pos2_lit", r, 32'h00000012);
    issue(1'b1, 2'b01, 1'b0, 12'h012, 32'h00005678, 0, r, e);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'd0, 0, r, e);
    chk("sh_lw_lit", r, 32'h567812EF);

    issue(1'b0, 2'b01, 1'b0, 12'h011, 32'd0, 0, r, e);
    chk("lh_mis_err", 32'(e), 32'd1);
    chk("lh_mis_rdata", r, 32'd0);
    issue(1'b1, 2'b10, 1'b0, 12'h012, 32'h11111111, 0, r, e);
    chk("sw_mis_err", 32'(e), 32'd1);
    chk("sw_mis_ram", ram_mem[12'h010 >> 2], 32'h567812EF);
    issue(1'b0, 2'b11, 1'b0, 12'h000, 32'd0, 2, r, e);
    chk("size11_err", 32'(e), 32'd1);

    issue(1'b1, 2'b10, 1'b0, 12'hFFC, 32'h80017F02, 0, r, e);
    issue(1'b0, 2'b01, 1'b0, 12'hFFE, 32'd0, 0, r, e);
    issue(1'b0, 2'b00, 1'b0, 12'hFFD, 32'd0, 0, r, e);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'd0, 5, r, e);
    chk("bp_lw_lit", r, 32'h567812EF);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
